pwm_led_array: RTL and testbench

Parametrised multi-channel PWM LED driver for the board's RGB and indicator LEDs. A shared period counter drives CH compare channels. Each channel has a double-buffered duty register, so a host write never glitches the current period. Each channel also has an optional breathing mode, which ramps brightness up and down automatically. It sits between the button/UI control logic (host write port) and the LED pins.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_fade_ch.sv | 115 +++++++++++
 rtl/pwm_led_array.sv | 95 +++++++++
 tb/tb_pwm_led_array.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared mode constants and helpers for the PWM LED array.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam logic MODE_STATIC  = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

    // Wide enough for any CW up to 16 plus the extra compare bit.
    localparam int c_WIDE_W = 17;
    typedef logic [c_WIDE_W-1:0] duty_wide_t;

    function automatic int ch_sel_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic duty_wide_t clamp_duty(input duty_wide_t duty, input duty_wide_t period);
        return (duty > period) ? period : duty;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fade_ch.sv
`default_nettype none
// ============================================================================
// Module  : pwm_fade_ch
// Brief   : One PWM channel: shadow/active duty, breathing ramp, output flop.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_fade_ch
    import pwm_pkg::*;
#(
    parameter int CW     = 9,
    parameter int PERIOD = 300
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] cnt_nxt,
    input  logic          wrap,
    input  logic          fade_step,
    input  logic          wr_stb,
    input  logic [CW-1:0] wr_duty,
    input  logic          wr_mode,
    output logic          restart,
    output logic          pwm_out
);

    typedef logic [CW:0] lvl_t;

    logic [CW-1:0] r_sh_duty;
    logic          r_sh_mode;
    lvl_t          r_peak;
    logic          r_mode;
    lvl_t          r_lvl;
    logic          r_dir_down;
    logic          r_pwm;

    logic          w_load;
    logic [CW-1:0] w_src_duty;
    logic          w_src_mode;
    lvl_t          w_src_peak;
    lvl_t          w_peak_nxt;
    logic          w_mode_nxt;
    logic          w_restart;
    logic          w_step;
    lvl_t          w_inc;
    lvl_t          w_dec;
    lvl_t          w_lvl_nxt;
    logic          w_dir_nxt;
    lvl_t          w_level_nxt;

    // A write in the load cycle bypasses the shadow so it lands in the new period.
    assign w_load     = wrap || !en;
    assign w_src_duty = wr_stb ? wr_duty : r_sh_duty;
    assign w_src_mode = wr_stb ? wr_mode : r_sh_mode;
    assign w_src_peak = lvl_t'(clamp_duty(duty_wide_t'(w_src_duty), duty_wide_t'(PERIOD)));

    assign w_peak_nxt = w_load ? w_src_peak : r_peak;
    assign w_mode_nxt = w_load ? w_src_mode : r_mode;
    assign w_restart  = w_load && ((w_src_mode != r_mode) || (w_src_peak < r_lvl));
    assign w_step     = fade_step && (w_src_mode == MODE_BREATHE);
    assign w_inc      = r_lvl + lvl_t'(1);
    assign w_dec      = r_lvl - lvl_t'(1);

    always_comb begin
        w_lvl_nxt = r_lvl;
        w_dir_nxt = r_dir_down;
        if (w_restart) begin
            w_lvl_nxt = '0;
            w_dir_nxt = 1'b0;
        end else if (w_step) begin
            if (w_src_peak == '0) begin
                w_lvl_nxt = '0;
                w_dir_nxt = 1'b0;
            end else if (!r_dir_down && (r_lvl < w_src_peak)) begin
                w_lvl_nxt = w_inc;
                w_dir_nxt = (w_inc == w_src_peak);
            end else if (r_lvl != '0) begin
                w_lvl_nxt = w_dec;
                w_dir_nxt = (w_dec != '0);
            end else begin
                w_lvl_nxt = w_inc;
                w_dir_nxt = (w_inc == w_src_peak);
            end
        end
    end

    // Compare against next-cycle count/level so the output flop shows cnt=0 right after the wrap.
    assign w_level_nxt = (w_mode_nxt == MODE_BREATHE) ? w_lvl_nxt : w_peak_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_duty  <= '0;
            r_sh_mode  <= MODE_STATIC;
            r_peak     <= '0;
            r_mode     <= MODE_STATIC;
            r_lvl      <= '0;
            r_dir_down <= 1'b0;
            r_pwm      <= 1'b0;
        end else begin
            if (wr_stb) begin
                r_sh_duty <= wr_duty;
                r_sh_mode <= wr_mode;
            end
            r_peak     <= w_peak_nxt;
            r_mode     <= w_mode_nxt;
            r_lvl      <= w_lvl_nxt;
            r_dir_down <= w_dir_nxt;
            r_pwm      <= en && ({1'b0, cnt_nxt} < w_level_nxt);
        end
    end

    assign restart = w_restart;
    assign pwm_out = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_led_array.sv
`default_nettype none
// ============================================================================
// Module  : pwm_led_array
// Brief   : Multi-channel PWM LED driver with shared period counter and fade divider.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_led_array
    import pwm_pkg::*;
#(
    parameter int CH       = 3,
    parameter int CW       = 9,
    parameter int PERIOD   = 300,
    parameter int FADE_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [ch_sel_w(CH)-1:0] wr_ch,
    input  logic [CW-1:0]           wr_duty,
    input  logic                    wr_mode,
    output logic [CH-1:0]           pwm_out,
    output logic                    period_tick
);

    localparam int c_SEL_W = ch_sel_w(CH);
    localparam int c_FD_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    typedef logic [CW-1:0]      cnt_t;
    typedef logic [c_FD_W-1:0]  fd_t;
    typedef logic [c_SEL_W-1:0] sel_t;

    cnt_t          r_cnt;
    cnt_t          w_cnt_nxt;
    fd_t           r_fdiv;
    logic          r_tick;
    logic          w_wrap;
    logic          w_fade_step;
    logic [CH-1:0] w_wr_stb;
    logic [CH-1:0] w_restart;

    assign w_wrap      = en && (r_cnt == cnt_t'(PERIOD - 1));
    assign w_fade_step = w_wrap && (r_fdiv == fd_t'(FADE_DIV - 1));

    always_comb begin
        w_cnt_nxt = r_cnt + cnt_t'(1);
        if (!en || w_wrap) begin
            w_cnt_nxt = '0;
        end
    end

    // Any channel restarting its ramp realigns the shared fade divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_fdiv <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= w_wrap;
            if (|w_restart) begin
                r_fdiv <= '0;
            end else if (w_wrap) begin
                r_fdiv <= w_fade_step ? fd_t'(0) : r_fdiv + fd_t'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            assign w_wr_stb[i] = wr_en && (wr_ch == sel_t'(i));

            pwm_fade_ch #(
                .CW     (CW),
                .PERIOD (PERIOD)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en),
                .cnt_nxt   (w_cnt_nxt),
                .wrap      (w_wrap),
                .fade_step (w_fade_step),
                .wr_stb    (w_wr_stb[i]),
                .wr_duty   (wr_duty),
                .wr_mode   (wr_mode),
                .restart   (w_restart[i]),
                .pwm_out   (pwm_out[i])
            );
        end
    endgenerate

    assign period_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_pwm_led_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_led_array
// Brief   : Directed self-checking bench for pwm_led_array (CH=3, PERIOD=300, FADE_DIV=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_led_array;

    localparam int CH       = 3;
    localparam int CW       = 9;
    localparam int PERIOD   = 300;
    localparam int FADE_DIV = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_duty;
    logic          wr_mode;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            hi [CH];
    logic [CH-1:0] contig;

    always #5 clk = ~clk;

    pwm_led_array #(
        .CH       (CH),
        .CW       (CW),
        .PERIOD   (PERIOD),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .wr_mode     (wr_mode),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic host_wr(input int ch, input int duty, input logic mode);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = CW'(duty);
        wr_mode = mode;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Counts negedges until period_tick is seen, bounded.
    task automatic wait_tick(input string tag, input int exp_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 2 * PERIOD);
        check(tag, n, exp_cycles);
    endtask

    // Entered on a tick cycle; samples one full period and optionally writes at cnt=wr_at.
    task automatic run_period(input string tag, input int wr_at, input int ch, input int duty,
                              input logic mode, input int e0, input int e1, input int e2);
        logic [CH-1:0] seen0 = '0;
        int            ex [CH];
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        check({tag, "_align"}, period_tick, 1);
        contig = '1;
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == wr_at) begin
                wr_en   = 1'b1;
                wr_ch   = 2'(ch);
                wr_duty = CW'(duty);
                wr_mode = mode;
            end else begin
                wr_en = 1'b0;
            end
            for (int c = 0; c < CH; c++) begin
                if (pwm_out[c]) begin
                    hi[c]++;
                    if (seen0[c]) contig[c] = 1'b0;
                end else begin
                    seen0[c] = 1'b1;
                end
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        for (int c = 0; c < CH; c++) check($sformatf("%s_ch%0d", tag, c), hi[c], ex[c]);
        check({tag, "_contig"}, contig, {CH{1'b1}});
    endtask

    initial begin
        int exp_b [8];
        exp_b = '{0, 1, 2, 3, 2, 1, 0, 1};

        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_tick", period_tick, 0);
        rst_n = 1'b1;
        @(negedge clk);

        host_wr(0, 150, 1'b0);
        host_wr(1, 0, 1'b0);
        host_wr(2, 300, 1'b0);
        en = 1'b1;
        wait_tick("en_first_tick", PERIOD);

        run_period("static",     -1,  0, 0,   1'b0, 150, 0,   300);
        run_period("pre",        10,  0, 100, 1'b0, 150, 0,   300);
        run_period("glitch_cur", 50,  0, 200, 1'b0, 100, 0,   300);
        run_period("glitch_nxt", 299, 1, 77,  1'b0, 200, 0,   300);
        run_period("wrap_wr",    299, 1, 400, 1'b0, 200, 77,  300);
        run_period("clamp",      5,   3, 5,   1'b0, 200, 300, 300);
        run_period("bad_ch",     20,  2, 3,   1'b1, 200, 300, 300);
        for (int k = 0; k < 8; k++) begin
            run_period($sformatf("breathe%0d", k), (k == 7) ? 100 : -1, 2, 10, 1'b0,
                       200, 300, exp_b[k]);
        end
        run_period("static10",   -1,  0, 0,   1'b0, 200, 300, 10);

        repeat (40) @(negedge clk);
        check("pre_disable_pwm", pwm_out, 3'b011);
        en = 1'b0;
        @(negedge clk);
        check("disable_pwm", pwm_out, 0);
        repeat (5) @(negedge clk);
        check("disabled_pwm", pwm_out, 0);
        check("disabled_tick", period_tick, 0);
        en = 1'b1;
        wait_tick("reenable_tick", PERIOD);
        run_period("reenable",   -1,  0, 0,   1'b0, 200, 300, 10);

        repeat (100) @(negedge clk);
        check("pre_reset_pwm", pwm_out, 3'b011);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm_out, 0);
        check("async_rst_tick", period_tick, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick("post_rst_tick", PERIOD);
        run_period("post_rst",   -1,  0, 0,   1'b0, 0,   0,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
